// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES core.
// Contents: byte/word typedefs, the state_e FSM encoding, the RCON table,
// nr_f (round count from key width), xtime, gf_mul and mix_column.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_e;

    // Index 0 and 11..15 are padding so a 4-bit round index never falls outside the table.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic int unsigned nr_f(input int unsigned key_width);
        return (key_width == 256) ? 14 : 10;
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; used only by the S-box inversion.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t p;
        byte_t m;
        acc = '0;
        p   = a;
        m   = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (m[0]) acc = acc ^ p;
            p = xtime(p);
            m = m >> 1;
        end
        return acc;
    endfunction

    // One MixColumns column; byte 0 (row 0) sits at [31:24].
    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        byte_t b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational key-schedule step. Given the current key window (Nk words,
// w[i-Nk] at the MSB) and the round index, produces the round key for that
// round and the window for the following round.
// Ports: key_win - current window; round - round index (1..NR);
//        next_win - window after this round; round_key - rk[round].
module aes_key_step
    import aes_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = 128
) (
    input  logic [KEY_WIDTH-1:0] key_win,
    input  logic [3:0]           round,
    output logic [KEY_WIDTH-1:0] next_win,
    output logic [127:0]         round_key
);

    localparam int unsigned NK = KEY_WIDTH / 32;

    word_t last_word;
    word_t sub_in;
    word_t temp;
    word_t nw0, nw1, nw2, nw3;
    byte_t sub_out [4];
    byte_t rcon;
    logic  rot_step;
    logic  expand;

    assign last_word = key_win[31:0];

    // AES-256: round 1 reuses the upper key half as-is; even rounds are the
    // i mod 8 == 0 steps (RotWord+Rcon[round/2]), odd rounds SubWord only.
    always_comb begin
        rot_step = (NK == 4) || !round[0];
        expand   = (NK == 4) || (round != 4'd1);
        rcon     = (NK == 4) ? RCON[round] : RCON[{1'b0, round[3:1]}];
        sub_in   = rot_step ? {last_word[23:0], last_word[31:24]} : last_word;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sub_word
        s_box u_s_box (
            .value (sub_in[31-8*g -: 8]),
            .subst (sub_out[g])
        );
    end

    always_comb begin
        temp = {sub_out[0], sub_out[1], sub_out[2], sub_out[3]};
        if (rot_step) temp[31:24] = temp[31:24] ^ rcon;
        nw0 = key_win[KEY_WIDTH-1  -: 32] ^ temp;
        nw1 = key_win[KEY_WIDTH-33 -: 32] ^ nw0;
        nw2 = key_win[KEY_WIDTH-65 -: 32] ^ nw1;
        nw3 = key_win[KEY_WIDTH-97 -: 32] ^ nw2;
        round_key = expand ? {nw0, nw1, nw2, nw3} : key_win[127:0];
    end

    if (NK == 8) begin : g_slide
        assign next_win = expand ? {key_win[127:0], round_key} : key_win;
    end else begin : g_replace
        assign next_win = round_key;
    end

endmodule

// File: rtl/s_box.sv
// AES forward S-box, computed as the GF(2^8) inverse (x^254) followed by
// the FIPS-197 affine transform.
// Ports: value - input byte; subst - substituted byte.
module s_box
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst
);

    always_comb begin
        byte_t p;
        byte_t inv;
        // x^254 = product of x^(2^k) for k = 1..7; zero maps to zero.
        p   = value;
        inv = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core, one full round per clock, AES-128 or AES-256.
// Ports: clk_i/rst_ni - clock, async active-low reset; clear_i - sync abort;
//        in_valid_i/in_ready_o, plain_text_i, cipher_key_i - input handshake;
//        out_valid_o/out_ready_i, cipher_text_o - output handshake (held until
//        accepted, zero when not valid); busy_o - high in ROUND or DONE.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned KEY_WIDTH  = 128,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] plain_text_i,
    input  logic [KEY_WIDTH-1:0]  cipher_key_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] cipher_text_o,
    output logic                  busy_o
);

    localparam int unsigned NR         = nr_f(KEY_WIDTH);
    localparam logic [3:0]  LAST_ROUND = 4'(NR);

    if (KEY_WIDTH != 128 && KEY_WIDTH != 256) begin : g_bad_key_width
        $error("aes_iter_core: KEY_WIDTH must be 128 or 256");
    end
    if (DATA_WIDTH != 128) begin : g_bad_data_width
        $error("aes_iter_core: DATA_WIDTH must be 128");
    end

    state_e                fsm_q, fsm_d;
    logic [DATA_WIDTH-1:0] state_q;
    logic [KEY_WIDTH-1:0]  key_q, next_key;
    logic [3:0]            round_q;
    logic [127:0]          round_key;
    logic                  last_round;
    byte_t                 sb_out [16];
    word_t                 round_cols [4];

    assign last_round = (round_q == LAST_ROUND);

    aes_key_step #(.KEY_WIDTH(KEY_WIDTH)) u_key_step (
        .key_win   (key_q),
        .round     (round_q),
        .next_win  (next_key),
        .round_key (round_key)
    );

    for (genvar g = 0; g < 16; g++) begin : g_sub_bytes
        s_box u_s_box (
            .value (state_q[DATA_WIDTH-1-8*g -: 8]),
            .subst (sb_out[g])
        );
    end

    // ShiftRows is pure wiring: row r of column c takes column (c+r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_column
        word_t shifted;
        assign shifted = {sb_out[4*c], sb_out[4*((c+1)%4)+1],
                          sb_out[4*((c+2)%4)+2], sb_out[4*((c+3)%4)+3]};
        assign round_cols[c] = (last_round ? shifted : mix_column(shifted))
                               ^ round_key[127-32*c -: 32];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fsm_q <= IDLE;
        else         fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        if (clear_i) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE:    if (in_valid_i)  fsm_d = ROUND;
                ROUND:   if (last_round)  fsm_d = DONE;
                DONE:    if (out_ready_i) fsm_d = IDLE;
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o    = 1'b0;
        out_valid_o   = 1'b0;
        busy_o        = 1'b0;
        cipher_text_o = '0;
        case (fsm_q)
            IDLE:  in_ready_o = 1'b1;
            ROUND: busy_o     = 1'b1;
            DONE: begin
                out_valid_o   = 1'b1;
                busy_o        = 1'b1;
                cipher_text_o = state_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else if (clear_i) begin
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q <= plain_text_i ^ cipher_key_i[KEY_WIDTH-1 -: 128];
                        key_q   <= cipher_key_i;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= {round_cols[0], round_cols[1], round_cols[2], round_cols[3]};
                    key_q   <= next_key;
                    round_q <= round_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
